// File: rtl/mdu_alu_seq.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/shift ops plus iterative multiply/divide.
// Define ALU_SIGNED_MD_EN to enable signed DIV (op 14) and REM (op 15).
module mdu_alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Ctr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             overflow
);
    localparam int CW = SHW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d, lo_q, lo_d, opd_q, opd_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
`ifdef ALU_SIGNED_MD_EN
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, sovf_q, sovf_d;
`endif

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res, hi_it, lo_it, fin_res;
    logic             alu_ovf, in_multi, fin_ovf;
    logic [WIDTH:0]   mul_sum, rem_sh;
    logic             rem_ge;

    assign shamt = B[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALU_Ctr)
            4'd0: alu_res = A & B;
            4'd1: alu_res = A | B;
            4'd2: begin
                alu_res = A + B;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            4'd3: alu_res = A ^ B;
            4'd4: alu_res = ~(A | B);
            4'd5: alu_res = A >> shamt;
            4'd6: begin
                alu_res = A - B;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            4'd7: alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'd8: alu_res = A << shamt;
            4'd9: alu_res = $unsigned($signed(A) >>> shamt);
            default: ;
        endcase
    end

    always_comb begin
        in_multi = ALU_Ctr inside {4'd10, 4'd11, 4'd12, 4'd13};
`ifdef ALU_SIGNED_MD_EN
        if (ALU_Ctr inside {4'd14, 4'd15}) in_multi = 1'b1;
`endif
    end

    // Shared iteration datapath. Multiply: hi = accumulator, lo = multiplier shifting out.
    // Divide: hi = partial remainder, lo = dividend shifting out / quotient shifting in.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        rem_ge  = rem_sh >= {1'b0, opd_q};
        if (op_q inside {4'd10, 4'd11}) begin
            {hi_it, lo_it} = {mul_sum, lo_q[WIDTH-1:1]};
        end else begin
            hi_it = rem_ge ? WIDTH'(rem_sh - {1'b0, opd_q}) : rem_sh[WIDTH-1:0];
            lo_it = {lo_q[WIDTH-2:0], rem_ge};
        end
    end

    always_comb begin
        fin_res = hi_it;
        fin_ovf = 1'b0;
        case (op_q)
            4'd10, 4'd12: fin_res = lo_it;
`ifdef ALU_SIGNED_MD_EN
            // Sign fix-up is folded into the last iteration so latency matches the unsigned ops.
            4'd14: begin
                fin_res = q_neg_q ? -lo_it : lo_it;
                fin_ovf = sovf_q;
            end
            4'd15: begin
                fin_res = r_neg_q ? -hi_it : hi_it;
                fin_ovf = sovf_q;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opd_d   = opd_q;
        op_d    = op_q;
`ifdef ALU_SIGNED_MD_EN
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        sovf_d  = sovf_q;
`endif
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_multi) begin
                        state_d = BUSY;
                        cnt_d   = CW'(WIDTH);
                        op_d    = ALU_Ctr;
                        hi_d    = '0;
                        if (ALU_Ctr inside {4'd10, 4'd11}) begin
                            lo_d  = B;
                            opd_d = A;
                        end else begin
                            lo_d  = A;
                            opd_d = B;
                        end
`ifdef ALU_SIGNED_MD_EN
                        if (ALU_Ctr inside {4'd14, 4'd15}) begin
                            lo_d    = A[WIDTH-1] ? -A : A;
                            opd_d   = B[WIDTH-1] ? -B : B;
                            q_neg_d = (A[WIDTH-1] ^ B[WIDTH-1]) && (B != '0);
                            r_neg_d = A[WIDTH-1];
                            sovf_d  = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (&B);
                        end
`endif
                    end else if (in_valid) begin
                        state_d = DONE;
                        res_d   = alu_res;
                        ovf_d   = alu_ovf;
                    end
                end
                BUSY: begin
                    hi_d  = hi_it;
                    lo_d  = lo_it;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = DONE;
                        res_d   = fin_res;
                        ovf_d   = fin_ovf;
                    end
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        zero_d = (res_d == '0);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opd_q   <= '0;
            op_q    <= '0;
`ifdef ALU_SIGNED_MD_EN
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            sovf_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opd_q   <= opd_d;
            op_q    <= op_d;
`ifdef ALU_SIGNED_MD_EN
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            sovf_q  <= sovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res       = res_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_mdu_alu_seq.sv
// Self-checking bench for mdu_alu_seq (WIDTH=32): directed vectors against a behavioural model.
// Define ALU_SIGNED_MD_EN here as for the RTL to exercise ops 14/15 as signed divide/remainder.
module tb_mdu_alu_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   ALU_Ctr = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         in_ready, out_valid, zero, overflow;
    logic [W-1:0] res;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_res = '0;
    logic         exp_ovf = 1'b0;
    logic         exp_pending = 1'b0;

    mdu_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALU_Ctr(ALU_Ctr), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic is_multi(input logic [3:0] op);
`ifdef ALU_SIGNED_MD_EN
        return op >= 4'd10;
`else
        return op inside {4'd10, 4'd11, 4'd12, 4'd13};
`endif
    endfunction

    // Behavioural reference: plain wide/signed arithmetic.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic o);
        logic signed [W-1:0] sa, sb;
        longint              s;
        logic [2*W-1:0]      p;
        sa = a;
        sb = b;
        o  = 1'b0;
        r  = '0;
        p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                s = longint'(sa) + longint'(sb);
                r = a + b;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3: r = a ^ b;
            4'd4: r = ~(a | b);
            4'd5: r = a >> b[4:0];
            4'd6: begin
                s = longint'(sa) - longint'(sb);
                r = a - b;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7: r = (sa < sb) ? 1 : 0;
            4'd8: r = a << b[4:0];
            4'd9: r = sa >>> b[4:0];
            4'd10: r = p[W-1:0];
            4'd11: r = p[2*W-1:W];
            4'd12: r = (b == 0) ? '1 : a / b;
            4'd13: r = (b == 0) ? a : a % b;
`ifdef ALU_SIGNED_MD_EN
            4'd14, 4'd15: begin
                if (b == 0) r = (op == 4'd14) ? '1 : a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    r = (op == 4'd14) ? a : '0;
                    o = 1'b1;
                end else r = (op == 4'd14) ? sa / sb : sa % sb;
            end
`endif
            default: ;
        endcase
    endfunction

    // Whenever the DUT presents a result, it must match the model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("valid_expected", exp_pending, 1'b1);
            check("res", res, exp_res);
            check("zero", zero, exp_res == '0);
            check("overflow", overflow, exp_ovf);
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        int           n;
        logic [W-1:0] r;
        logic         o;
        model(op, a, b, r, o);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        exp_res = r;
        exp_ovf = o;
        exp_pending = 1'b1;
        ALU_Ctr = op; A = a; B = b; in_valid = 1'b1; out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n <= 2 * W) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, is_multi(op) ? W + 1 : 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            ALU_Ctr = 4'd1; A = ~a; B = b; in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("retire_out_valid", out_valid, 1'b0);
        check("retire_in_ready", in_ready, 1'b1);
        exp_pending = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_res"}, res, 0);
        check({tag, "_zero"}, zero, 1'b1);
        check({tag, "_overflow"}, overflow, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r, prev;
        logic         o, saw;

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed anchors for the model itself.
        model(4'd2, 32'h7FFFFFFF, 32'd1, r, o);        check("pin_add", {o, r}, {1'b1, 32'h80000000});
        model(4'd9, 32'h80000010, 32'h24, r, o);       check("pin_sra", r, 32'hF8000001);
        model(4'd7, 32'hFFFFFFFF, 32'd0, r, o);        check("pin_slt", r, 32'd1);
        model(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, r, o); check("pin_mulhu", r, 32'hFFFFFFFE);
        model(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, r, o); check("pin_mullo", r, 32'd1);
        model(4'd12, 32'd100, 32'd7, r, o);            check("pin_divu", r, 32'd14);
        model(4'd13, 32'd100, 32'd7, r, o);            check("pin_remu", r, 32'd2);
        model(4'd12, 32'd5, 32'd0, r, o);              check("pin_divu0", r, 32'hFFFFFFFF);
        model(4'd13, 32'd5, 32'd0, r, o);              check("pin_remu0", r, 32'd5);
`ifdef ALU_SIGNED_MD_EN
        model(4'd14, -32'sd7, 32'd2, r, o);            check("pin_div", r, 32'hFFFFFFFD);
        model(4'd15, -32'sd7, 32'd2, r, o);            check("pin_rem", r, 32'hFFFFFFFF);
        model(4'd14, 32'h80000000, 32'hFFFFFFFF, r, o); check("pin_div_ovf", {o, r}, {1'b1, 32'h80000000});
`endif

        run_op(4'd2,  32'h7FFFFFFF, 32'd1, 0);
        run_op(4'd9,  32'h80000010, 32'h24, 0);
        run_op(4'd7,  32'hFFFFFFFF, 32'd0, 0);
        run_op(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(4'd12, 32'd100, 32'd7, 0);
        run_op(4'd13, 32'd100, 32'd7, 0);
        run_op(4'd12, 32'd5, 32'd0, 0);
        run_op(4'd13, 32'd5, 32'd0, 0);
        run_op(4'd0,  32'hF0F01234, 32'h0FF0FF00, 0);
        run_op(4'd1,  32'hF0F01234, 32'h0FF0FF00, 0);
        run_op(4'd4,  32'hF0F01234, 32'h0FF0FF00, 0);
        run_op(4'd5,  32'h80000000, 32'd31, 0);
        run_op(4'd6,  32'h80000000, 32'd1, 0);
        run_op(4'd6,  32'd5, 32'd5, 0);
        run_op(4'd8,  32'd1, 32'd33, 0);
        run_op(4'd10, 32'd12345, 32'd6789, 0);
        run_op(4'd12, 32'hFFFFFFFF, 32'd3, 0);
        run_op(4'd14, -32'sd7, 32'd2, 0);
        run_op(4'd15, -32'sd7, 32'd2, 0);
        run_op(4'd14, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(4'd14, -32'sd8, 32'd0, 0);
        run_op(4'd15, -32'sd8, 32'd0, 0);
        run_op(4'd3,  32'hDEADBEEF, 32'h12345678, 5);

        // Flush a divide at its tenth busy cycle.
        prev = exp_res;
        @(negedge clk);
        ALU_Ctr = 4'd12; A = 32'd100; B = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("flush_busy_in_ready", in_ready, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_res", res, prev);
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw |= out_valid;
        end
        check("flush_never_valid", saw, 1'b0);

        // Flush and in_valid together in IDLE: nothing accepted.
        @(negedge clk);
        ALU_Ctr = 4'd2; A = 32'd1; B = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        check("flush_idle_out_valid", out_valid, 1'b0);
        check("flush_idle_res", res, prev);

        // Reset in the middle of a multiply.
        @(negedge clk);
        ALU_Ctr = 4'd11; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_values("midbusy_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd2, 32'd40, 32'd2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
